// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Data-memory responder behind the execute-stage request port.
//            Accepts one read and/or byte-masked write per request, services
//            it from an internal word-organised RAM after LATENCY cycles and
//            returns an aligned 32-bit word plus an error flag through a
//            valid/ready response handshake. One request in flight at most.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_valid_i/ready_o - request handshake
//            rmem_ena_i/addr_i   - read enable and byte address
//            wmem_ena_i/addr_i   - write enable and byte address
//            wmem_mask_i         - byte-lane enables (bits [3:0] used)
//            wmem_data_i         - lane-positioned write data
//            rmem_data_o         - aligned read word
//            resp_err_o          - an enabled address was out of range
//            resp_valid_o/ready_i- response handshake
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        rmem_ena_i,
    input  logic [31:0] rmem_addr_i,
    input  logic        wmem_ena_i,
    input  logic [31:0] wmem_addr_i,
    input  logic [7:0]  wmem_mask_i,
    input  logic [31:0] wmem_data_i,
    output logic [31:0] rmem_data_o,
    output logic        resp_err_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i
);

    localparam int          c_depth    = 1 << DEPTH_LOG2;
    localparam logic [32:0] c_span     = 33'd4 << DEPTH_LOG2;
    localparam logic [3:0]  c_cnt_load = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] raddr_q, raddr_d;
    logic [31:0] waddr_q, waddr_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [c_depth];

    // Operands of the access actually being performed this cycle.
    logic        w_acc_rd, w_acc_wr;
    logic [31:0] w_acc_raddr, w_acc_waddr, w_acc_wdata;
    logic [3:0]  w_acc_mask;
    logic        w_access;

    logic        w_req_ready;
    logic        w_accept;
    logic [32:0] w_roff, w_woff;
    logic        w_rin, w_win;
    logic [DEPTH_LOG2-1:0] w_ridx, w_widx;
    logic [31:0] w_rword;
    logic        w_err;
    logic [31:0] w_rdata;
    logic        w_commit;
    logic        w_unused;

    assign w_req_ready  = (state_q == ST_IDLE) && !rst;
    assign w_accept     = req_valid_i && w_req_ready;
    assign req_ready_o  = w_req_ready;
    assign resp_valid_o = (state_q == ST_RESP);
    assign rmem_data_o  = rdata_q;
    assign resp_err_o   = err_q;

    generate
        if (LATENCY == 1) begin : g_lat_one
            // Access happens on the acceptance edge itself, straight from the inputs.
            assign w_acc_rd    = rmem_ena_i;
            assign w_acc_wr    = wmem_ena_i;
            assign w_acc_raddr = rmem_addr_i;
            assign w_acc_waddr = wmem_addr_i;
            assign w_acc_mask  = wmem_mask_i[3:0];
            assign w_acc_wdata = wmem_data_i;
            assign w_access    = w_accept;
        end else begin : g_lat_multi
            // Counter value 1 in WAIT marks the edge that completes the latency.
            assign w_acc_rd    = rd_en_q;
            assign w_acc_wr    = wr_en_q;
            assign w_acc_raddr = raddr_q;
            assign w_acc_waddr = waddr_q;
            assign w_acc_mask  = mask_q;
            assign w_acc_wdata = wdata_q;
            assign w_access    = (state_q == ST_WAIT) && (cnt_q == 4'd1);
        end
    endgenerate

    // Offsets in 33 bits so addresses below BASE_ADDR show up as a borrow
    // instead of wrapping into the RAM window.
    assign w_roff  = {1'b0, w_acc_raddr} - {1'b0, BASE_ADDR};
    assign w_woff  = {1'b0, w_acc_waddr} - {1'b0, BASE_ADDR};
    assign w_rin   = !w_roff[32] && (w_roff < c_span);
    assign w_win   = !w_woff[32] && (w_woff < c_span);
    assign w_ridx  = w_roff[DEPTH_LOG2+1:2];
    assign w_widx  = w_woff[DEPTH_LOG2+1:2];
    assign w_rword = mem[w_ridx];

    // A single bad enabled address poisons the whole request.
    assign w_err    = (w_acc_rd && !w_rin) || (w_acc_wr && !w_win);
    assign w_rdata  = (w_acc_rd && !w_err) ? w_rword : 32'd0;
    assign w_commit = w_access && w_acc_wr && !w_err && !rst;

    assign w_unused = ^{wmem_mask_i[7:4], w_roff[1:0], w_woff[1:0]};

    // RAM: not reset. The read above sees pre-write contents on a combined request.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int n = 0; n < 4; n++) begin
                if (w_acc_mask[n]) begin
                    mem[w_widx][8*n +: 8] <= w_acc_wdata[8*n +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_en_d = rd_en_q;
        wr_en_d = wr_en_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        mask_d  = mask_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    rd_en_d = rmem_ena_i;
                    wr_en_d = wmem_ena_i;
                    raddr_d = rmem_addr_i;
                    waddr_d = wmem_addr_i;
                    mask_d  = wmem_mask_i[3:0];
                    wdata_d = wmem_data_i;
                    cnt_d   = c_cnt_load;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completing access overrides the per-state defaults above.
        if (w_access) begin
            rdata_d = w_rdata;
            err_d   = w_err;
            cnt_d   = 4'd0;
            state_d = ST_RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            raddr_q <= 32'd0;
            waddr_q <= 32'd0;
            mask_q  <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Randomised scoreboard bench for data_mem_responder. A driver
//            issues requests and pushes expected responses from an array
//            model of the RAM; an independent monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int          DEPTH_LOG2 = 10;
    localparam logic [31:0] BASE_ADDR  = 32'h8000_0000;
    localparam int          LATENCY    = 2;
    localparam int          c_depth    = 1 << DEPTH_LOG2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        rmem_ena_i;
    logic [31:0] rmem_addr_i;
    logic        wmem_ena_i;
    logic [31:0] wmem_addr_i;
    logic [7:0]  wmem_mask_i;
    logic [31:0] wmem_data_i;
    logic [31:0] rmem_data_o;
    logic        resp_err_o;
    logic        resp_valid_o;
    logic        resp_ready_i;

    data_mem_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .BASE_ADDR  (BASE_ADDR),
        .LATENCY    (LATENCY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .rmem_ena_i   (rmem_ena_i),
        .rmem_addr_i  (rmem_addr_i),
        .wmem_ena_i   (wmem_ena_i),
        .wmem_addr_i  (wmem_addr_i),
        .wmem_mask_i  (wmem_mask_i),
        .wmem_data_i  (wmem_data_i),
        .rmem_data_o  (rmem_data_o),
        .resp_err_o   (resp_err_o),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [c_depth];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          ready_pct = 70;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain byte-address arithmetic on a word array.
    function automatic bit in_range(logic [31:0] a);
        longint off;
        off = longint'({32'd0, a}) - longint'({32'd0, BASE_ADDR});
        return (off >= 0) && (off < 4 * c_depth);
    endfunction

    function automatic int widx(logic [31:0] a);
        longint off;
        off = longint'({32'd0, a}) - longint'({32'd0, BASE_ADDR});
        return int'(off / 4);
    endfunction

    task automatic do_req(bit rd, logic [31:0] ra, bit wr, logic [31:0] wa,
                          logic [7:0] m, logic [31:0] wd, bit track);
        int   t;
        exp_t e;
        logic [31:0] w;
        t = 0;
        @(negedge clk);
        while (!req_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready_o) begin
            n_vec++;
            n_fail++;
            $display("FAIL req_ready_timeout: got 0, expected 1 (cycle %0d)", cyc);
            return;
        end
        rmem_ena_i  = rd;
        rmem_addr_i = ra;
        wmem_ena_i  = wr;
        wmem_addr_i = wa;
        wmem_mask_i = m;
        wmem_data_i = wd;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs: only the acceptance-edge values may matter.
        req_valid_i = 1'b0;
        rmem_ena_i  = 1'($urandom);
        wmem_ena_i  = 1'($urandom);
        rmem_addr_i = $urandom;
        wmem_addr_i = $urandom;
        wmem_mask_i = 8'($urandom);
        wmem_data_i = $urandom;
        if (track) begin
            e.acc = cyc;
            e.err = (rd && !in_range(ra)) || (wr && !in_range(wa));
            e.data = (rd && !e.err) ? model[widx(ra)] : 32'd0;
            if (wr && !e.err) begin
                w = model[widx(wa)];
                for (int n = 0; n < 4; n++)
                    if (m[n]) w[8*n +: 8] = wd[8*n +: 8];
                model[widx(wa)] = w;
            end
            sb_q.push_back(e);
        end
    endtask

    // Monitor: pops an expectation on each new response and holds it until consumed.
    initial begin
        bit   have_cur;
        exp_t cur;
        have_cur = 0;
        resp_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_cur = 0;
                resp_ready_i = 1'b0;
            end else if (resp_valid_o) begin
                if (!have_cur) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_resp", 32'd1, 32'd0);
                        cur.data = rmem_data_o;
                        cur.err  = resp_err_o;
                    end else begin
                        cur = sb_q.pop_front();
                        check("resp_latency", cyc, cur.acc + LATENCY - 1);
                        check("resp_data", rmem_data_o, cur.data);
                        check("resp_err", {31'd0, resp_err_o}, {31'd0, cur.err});
                    end
                    have_cur = 1;
                end else begin
                    check("hold_data", rmem_data_o, cur.data);
                    check("hold_err", {31'd0, resp_err_o}, {31'd0, cur.err});
                    check("hold_req_ready", {31'd0, req_ready_o}, 32'd0);
                end
                resp_ready_i = ($urandom_range(99) < ready_pct);
                if (resp_ready_i) have_cur = 0;
            end else begin
                resp_ready_i = 1'($urandom);
            end
        end
    end

    initial begin
        int t;
        logic [31:0] a;
        rst = 1'b1;
        req_valid_i = 1'b1;
        rmem_ena_i = 1'b1; rmem_addr_i = BASE_ADDR;
        wmem_ena_i = 1'b1; wmem_addr_i = BASE_ADDR;
        wmem_mask_i = 8'hFF; wmem_data_i = 32'hFFFF_FFFF;

        // Reset held three cycles with a request pending.
        repeat (3) begin
            @(negedge clk);
            check("rst_req_ready", {31'd0, req_ready_o}, 32'd0);
            check("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
            check("rst_data", rmem_data_o, 32'd0);
            check("rst_err", {31'd0, resp_err_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", {31'd0, req_ready_o}, 32'd1);

        // Fill the whole RAM so every later read has a defined value.
        ready_pct = 100;
        for (int i = 0; i < c_depth; i++)
            do_req(1'b0, 32'd0, 1'b1, BASE_ADDR + 32'(4 * i), 8'hFF, $urandom, 1'b1);
        ready_pct = 70;

        // Word write / unaligned read.
        do_req(1'b0, 32'd0, 1'b1, 32'h8000_0010, 8'h0F, 32'hDEAD_BEEF, 1'b1);
        do_req(1'b1, 32'h8000_0013, 1'b0, 32'd0, 8'h00, 32'd0, 1'b1);
        // Byte merge.
        do_req(1'b0, 32'd0, 1'b1, 32'h8000_0020, 8'h0F, 32'h1122_3344, 1'b1);
        do_req(1'b0, 32'd0, 1'b1, 32'h8000_0020, 8'hF4, 32'h00AA_0000, 1'b1);
        do_req(1'b1, 32'h8000_0020, 1'b0, 32'd0, 8'h00, 32'd0, 1'b1);
        check("byte_merge_model", model[8], 32'h11AA_3344);
        // Combined read+write of the same word.
        do_req(1'b0, 32'd0, 1'b1, 32'h8000_0030, 8'h0F, 32'h0000_0001, 1'b1);
        do_req(1'b1, 32'h8000_0030, 1'b1, 32'h8000_0030, 8'h0F, 32'h0000_0002, 1'b1);
        do_req(1'b1, 32'h8000_0030, 1'b0, 32'd0, 8'h00, 32'd0, 1'b1);
        // Out of range on both sides, then the boundary words.
        do_req(1'b1, 32'h7FFF_FFFC, 1'b1, 32'h8000_1000, 8'h0F, 32'hCAFE_F00D, 1'b1);
        do_req(1'b0, 32'd0, 1'b1, 32'h7FFF_FFFC, 8'h0F, 32'h1234_5678, 1'b1);
        do_req(1'b1, 32'h8000_0FFC, 1'b1, 32'h8000_1000, 8'h0F, 32'h1234_5678, 1'b1);
        do_req(1'b1, 32'h8000_0FFC, 1'b0, 32'd0, 8'h00, 32'd0, 1'b1);
        do_req(1'b1, 32'h8000_0000, 1'b0, 32'd0, 8'h00, 32'd0, 1'b1);
        // Neither enable and mask-zero write.
        do_req(1'b0, 32'h8000_0040, 1'b0, 32'h8000_0040, 8'h0F, 32'h5555_5555, 1'b1);
        do_req(1'b0, 32'd0, 1'b1, 32'h8000_0040, 8'hF0, 32'h6666_6666, 1'b1);
        do_req(1'b1, 32'h8000_0040, 1'b0, 32'd0, 8'h00, 32'd0, 1'b1);

        // Backpressure: response must hold while the consumer stalls.
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        ready_pct = 0;
        do_req(1'b1, 32'h8000_0010, 1'b0, 32'd0, 8'h00, 32'd0, 1'b1);
        repeat (LATENCY + 6) @(negedge clk);
        ready_pct = 100;

        // Reset while a write is in WAIT: dropped, no response, RAM unchanged.
        do_req(1'b0, 32'd0, 1'b1, 32'h8000_0050, 8'h0F, 32'hBAD0_BAD0, 1'b0);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        do_req(1'b1, 32'h8000_0050, 1'b0, 32'd0, 8'h00, 32'd0, 1'b1);
        ready_pct = 70;

        // Randomised traffic, mostly in range with boundary-biased strays.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra, wa;
            ra = BASE_ADDR + ($urandom_range(c_depth * 4 - 1));
            wa = BASE_ADDR + ($urandom_range(63) * 4) + $urandom_range(3);
            case ($urandom_range(9))
                0: ra = BASE_ADDR - 32'($urandom_range(8) + 1);
                1: wa = BASE_ADDR + 32'(c_depth * 4) + $urandom_range(7);
                2: ra = $urandom;
                default: ;
            endcase
            a = $urandom;
            do_req(1'($urandom), ra, 1'($urandom), wa, 8'($urandom), a, 1'b1);
        end

        t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("scoreboard_drained", sb_q.size(), 32'd0);
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
